// File: rtl/hc_lane_dispatch.sv
// ---------------------------------------------------------------------------
// hc_lane_dispatch
//
// Fans incoming cache-line beats out to NUM_LANES kernel lanes in strict
// round-robin order. Each lane's results are buffered in a small per-lane
// FIFO and collected back in the same round-robin order, so results leave in
// the order their beats arrived. A credit counter tracks beats that have
// been accepted but not yet delivered. It drives an almost-full warning
// toward the requestor and rejects beats once every slot is spoken for.
//
// Ports:
//   clk             single clock
//   reset           synchronous, active-high reset
//   data_in         beat from the requestor
//   valid_in        beat qualifier; accepted unless the credit pool is exhausted
//   almfull_out     requestor must stop within ALMFULL_SLACK beats
//   data_out        in-order result beat
//   valid_out       result qualifier
//   ready_in        downstream accepts data_out when valid_out is also high
//   lane_data_out   per-lane dispatched beat; lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   lane_valid_out  per-lane one-cycle dispatch strobe
//   lane_data_in    per-lane result beat
//   lane_valid_in   per-lane result strobe
//   outstanding     beats accepted but not yet delivered
//   overflow_err    sticky protocol-violation flag
// ---------------------------------------------------------------------------
module hc_lane_dispatch #(
    parameter int DATA_WIDTH    = 512,
    parameter int NUM_LANES     = 4,
    parameter int FIFO_DEPTH    = 16,
    parameter int ALMFULL_SLACK = 8,
    localparam int CAP          = NUM_LANES * FIFO_DEPTH,
    localparam int CNT_W        = $clog2(CAP) + 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DATA_WIDTH-1:0]           data_in,
    input  logic                            valid_in,
    output logic                            almfull_out,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic                            valid_out,
    input  logic                            ready_in,
    output logic [NUM_LANES*DATA_WIDTH-1:0] lane_data_out,
    output logic [NUM_LANES-1:0]            lane_valid_out,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] lane_data_in,
    input  logic [NUM_LANES-1:0]            lane_valid_in,
    output logic [CNT_W-1:0]                outstanding,
    output logic                            overflow_err
);

    localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] CAP_CNT   = CNT_W'(CAP);
    localparam logic [CNT_W-1:0] AF_THRESH = CNT_W'(CAP - ALMFULL_SLACK);
    localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(NUM_LANES - 1);

    logic [PTR_W-1:0]                r_dispPtr;
    logic [PTR_W-1:0]                r_colPtr;
    logic [CNT_W-1:0]                r_outstanding;
    logic                            r_overflowErr;
    logic [NUM_LANES*DATA_WIDTH-1:0] r_laneData;
    logic [NUM_LANES-1:0]            r_laneValid;
    logic [DATA_WIDTH-1:0]           r_dataOut;
    logic                            r_validOut;

    logic                  w_handshake;
    logic                  w_atCap;
    logic                  w_accept;
    logic                  w_inOverflow;
    logic                  w_load;
    logic                  w_headEmpty;
    logic [DATA_WIDTH-1:0] w_headData;
    logic [NUM_LANES-1:0]  w_fifoEmpty;
    logic [NUM_LANES-1:0]  w_fifoFull;
    logic [NUM_LANES-1:0]  w_fifoPop;
    logic [NUM_LANES-1:0]  w_fifoDrop;
    logic [DATA_WIDTH-1:0] w_fifoHead [NUM_LANES];

    // A beat is only refused when every credit is in use and no delivery is
    // freeing one up in the same cycle; a simultaneous handshake makes room.
    assign w_handshake  = r_validOut & ready_in;
    assign w_atCap      = (r_outstanding == CAP_CNT);
    assign w_accept     = valid_in & ~(w_atCap & ~w_handshake);
    assign w_inOverflow = valid_in & w_atCap & ~w_handshake;

    // The output register refills whenever it is empty or draining, but only
    // from the lane that holds the next result in arrival order. If that lane
    // is still empty we wait even if other lanes have results ready.
    assign w_headEmpty = w_fifoEmpty[r_colPtr];
    assign w_headData  = w_fifoHead[r_colPtr];
    assign w_load      = (~r_validOut | w_handshake) & ~w_headEmpty;

    // Only the lane being collected from can be popped, and only when the
    // output register actually takes its head entry.
    always_comb begin
        w_fifoPop = '0;
        if (w_load) begin
            w_fifoPop[r_colPtr] = 1'b1;
        end
    end

    // One result FIFO per lane. The pointers carry an extra wrap bit so that
    // full and empty can be told apart without a separate count. Storage is
    // not reset; emptiness comes entirely from the pointers.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
        logic [AW:0]           r_wrPtr;
        logic [AW:0]           r_rdPtr;
        logic                  w_write;

        assign w_fifoEmpty[k] = (r_wrPtr == r_rdPtr);
        assign w_fifoFull[k]  = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                                (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
        assign w_write        = lane_valid_in[k] & ~w_fifoFull[k] & ~reset;
        assign w_fifoDrop[k]  = lane_valid_in[k] & w_fifoFull[k];
        assign w_fifoHead[k]  = r_mem[r_rdPtr[AW-1:0]];

        // Pointer update: a result arriving during reset is discarded because
        // reset wins over both the write and the pop.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_wrPtr <= '0;
                r_rdPtr <= '0;
            end else begin
                if (w_write) begin
                    r_wrPtr <= r_wrPtr + (AW+1)'(1);
                end
                if (w_fifoPop[k]) begin
                    r_rdPtr <= r_rdPtr + (AW+1)'(1);
                end
            end
        end

        // Result storage: written the same edge the write pointer moves, so
        // the entry is readable by the collector on the very next edge.
        always_ff @(posedge clk) begin
            if (w_write) begin
                r_mem[r_wrPtr[AW-1:0]] <= lane_data_in[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Dispatch stage: an accepted beat is registered onto the lane the
    // dispatch pointer names, with a single-cycle strobe. Slices belonging
    // to other lanes keep their previous contents. A refused beat leaves the
    // pointer where it was so the round-robin sequence is not disturbed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dispPtr   <= '0;
            r_laneValid <= '0;
            r_laneData  <= '0;
        end else begin
            r_laneValid <= '0;
            if (w_accept) begin
                for (int k = 0; k < NUM_LANES; k++) begin
                    if (r_dispPtr == PTR_W'(k)) begin
                        r_laneValid[k]                          <= 1'b1;
                        r_laneData[k*DATA_WIDTH +: DATA_WIDTH] <= data_in;
                    end
                end
                r_dispPtr <= (r_dispPtr == LAST_LANE) ? '0 : r_dispPtr + PTR_W'(1);
            end
        end
    end

    // Credit counter: one credit per accepted beat, returned when the beat
    // finally leaves through the output handshake. Both in one cycle cancel.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_outstanding <= '0;
        end else begin
            case ({w_accept, w_handshake})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Sticky error: set by a refused input beat or by a lane writing into a
    // full result FIFO, and held until the next reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflowErr <= 1'b0;
        end else if (w_inOverflow || (|w_fifoDrop)) begin
            r_overflowErr <= 1'b1;
        end
    end

    // Output register and collect pointer. While valid_out is high and the
    // downstream is stalling, nothing here changes, which keeps data_out and
    // valid_out stable. The collect pointer follows the same round-robin
    // order as dispatch, which is what restores arrival order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dataOut  <= '0;
            r_validOut <= 1'b0;
            r_colPtr   <= '0;
        end else if (w_load) begin
            r_dataOut  <= w_headData;
            r_validOut <= 1'b1;
            r_colPtr   <= (r_colPtr == LAST_LANE) ? '0 : r_colPtr + PTR_W'(1);
        end else if (w_handshake) begin
            r_validOut <= 1'b0;
        end
    end

    assign almfull_out    = (r_outstanding >= AF_THRESH);
    assign outstanding    = r_outstanding;
    assign overflow_err   = r_overflowErr;
    assign data_out       = r_dataOut;
    assign valid_out      = r_validOut;
    assign lane_data_out  = r_laneData;
    assign lane_valid_out = r_laneValid;

endmodule

// File: tb/tb_hc_lane_dispatch.sv
// ---------------------------------------------------------------------------
// tb_hc_lane_dispatch
//
// Bench for hc_lane_dispatch. A four-lane instance is driven by directed
// sequences and random traffic while a monitor keeps an arrival-order queue
// of accepted beats, a credit count and the expected lane contents. A
// second single-lane instance covers the degenerate FIFO configuration.
// ---------------------------------------------------------------------------
module tb_hc_lane_dispatch;

    localparam int DW     = 512;
    localparam int NL     = 4;
    localparam int FD     = 16;
    localparam int SLACK  = 8;
    localparam int CAP    = NL * FD;
    localparam int CW     = $clog2(CAP) + 1;
    localparam int THRESH = CAP - SLACK;

    localparam int DW1 = 32;
    localparam int FD1 = 4;
    localparam int CW1 = $clog2(FD1) + 1;

    logic             clk;
    logic             reset;
    logic [DW-1:0]    dataIn;
    logic             validIn;
    logic             almfullOut;
    logic [DW-1:0]    dataOut;
    logic             validOut;
    logic             readyIn;
    logic [NL*DW-1:0] laneDataOut;
    logic [NL-1:0]    laneValidOut;
    logic [NL*DW-1:0] laneDataIn = '0;
    logic [NL-1:0]    laneValidIn = '0;
    logic [CW-1:0]    outstanding;
    logic             overflowErr;

    logic [DW1-1:0] sDataIn;
    logic           sValidIn;
    logic           sAlmfull;
    logic [DW1-1:0] sDataOut;
    logic           sValidOut;
    logic           sReadyIn;
    logic [DW1-1:0] sLaneDataOut;
    logic [0:0]     sLaneValidOut;
    logic [DW1-1:0] sLaneDataIn = '0;
    logic [0:0]     sLaneValidIn = '0;
    logic [CW1-1:0] sOutstanding;
    logic           sOverflowErr;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    hc_lane_dispatch #(
        .DATA_WIDTH(DW), .NUM_LANES(NL), .FIFO_DEPTH(FD), .ALMFULL_SLACK(SLACK)
    ) dut (
        .clk(clk), .reset(reset), .data_in(dataIn), .valid_in(validIn),
        .almfull_out(almfullOut), .data_out(dataOut), .valid_out(validOut),
        .ready_in(readyIn), .lane_data_out(laneDataOut), .lane_valid_out(laneValidOut),
        .lane_data_in(laneDataIn), .lane_valid_in(laneValidIn),
        .outstanding(outstanding), .overflow_err(overflowErr)
    );

    hc_lane_dispatch #(
        .DATA_WIDTH(DW1), .NUM_LANES(1), .FIFO_DEPTH(FD1), .ALMFULL_SLACK(2)
    ) dutSingle (
        .clk(clk), .reset(reset), .data_in(sDataIn), .valid_in(sValidIn),
        .almfull_out(sAlmfull), .data_out(sDataOut), .valid_out(sValidOut),
        .ready_in(sReadyIn), .lane_data_out(sLaneDataOut), .lane_valid_out(sLaneValidOut),
        .lane_data_in(sLaneDataIn), .lane_valid_in(sLaneValidIn),
        .outstanding(sOutstanding), .overflow_err(sOverflowErr)
    );

    // Free-running clock and a cycle index shared by the lane models and
    // the monitor.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // One comparison: counts it, and reports it when it does not hold.
    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [DW-1:0] randBeat();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) begin
            r[i*32 +: 32] = $urandom;
        end
        return r;
    endfunction

    // Behavioural model of the four-lane instance: a queue of beats in
    // arrival order, the credit count, the sticky error, and what each
    // lane output slice should currently hold.
    logic [DW-1:0] expQ [$];
    logic [DW-1:0] mLaneData [NL];
    logic [NL-1:0] mLaneValid = '0;
    int            mCount     = 0;
    bit            mErr       = 1'b0;
    int            mAccepted  = 0;
    int            mOutIdx    = 0;
    bit            prevStall  = 1'b0;
    logic [DW-1:0] prevData   = '0;
    int            outCyc [256];

    initial begin
        for (int k = 0; k < NL; k++) begin
            mLaneData[k] = '0;
        end
    end

    // Monitor on the falling edge: compare the DUT against the model, then
    // advance the model by what the coming rising edge will do.
    always @(negedge clk) begin
        logic          hs;
        logic          acc;
        int            lane;
        logic [DW-1:0] front;

        checkOutput("outstanding", DW'(outstanding), DW'(mCount));
        checkOutput("almfull", DW'(almfullOut), DW'(mCount >= THRESH));
        checkOutput("overflowErr", DW'(overflowErr), DW'(mErr));
        checkOutput("laneValidOut", DW'(laneValidOut), DW'(mLaneValid));
        for (int k = 0; k < NL; k++) begin
            checkOutput("laneDataOut", laneDataOut[k*DW +: DW], mLaneData[k]);
        end
        if (prevStall) begin
            checkOutput("holdValid", DW'(validOut), DW'(1'b1));
            checkOutput("holdData", dataOut, prevData);
        end

        hs = validOut && readyIn;
        if (reset) begin
            mCount     = 0;
            mErr       = 1'b0;
            mLaneValid = '0;
            mAccepted  = 0;
            mOutIdx    = 0;
            prevStall  = 1'b0;
            expQ.delete();
            for (int k = 0; k < NL; k++) begin
                mLaneData[k] = '0;
            end
        end else begin
            if (hs) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL spuriousOutput: got %0h expected no beat", dataOut);
                end else begin
                    front = expQ.pop_front();
                    checkOutput("dataOut", dataOut, front);
                    if (mOutIdx < 256) begin
                        outCyc[mOutIdx] = cyc;
                    end
                    mOutIdx++;
                end
            end
            acc = validIn && !(mCount == CAP && !hs);
            if (validIn && !acc) begin
                mErr = 1'b1;
            end
            mLaneValid = '0;
            if (acc) begin
                lane             = mAccepted % NL;
                mLaneValid[lane] = 1'b1;
                mLaneData[lane]  = dataIn;
                expQ.push_back(dataIn);
                mAccepted++;
            end
            mCount    = mCount + (acc ? 1 : 0) - (hs ? 1 : 0);
            prevStall = validOut && !readyIn;
            prevData  = dataOut;
        end
    end

    // Kernel lane models: each lane echoes its beats after a per-lane (or
    // random) latency, always in its own input order. While reset is high
    // the pending work is thrown away and, when asked, junk results are
    // driven that the DUT must ignore.
    typedef struct packed {
        logic [DW-1:0] d;
        logic [31:0]   due;
    } ret_t;

    ret_t laneQ [NL][$];
    int   lat [NL] = '{1, 1, 1, 1};
    bit   randLat  = 1'b0;
    bit   junk     = 1'b0;

    always @(posedge clk) begin
        ret_t r;
        int   dueC;
        #2;
        laneValidIn = '0;
        if (reset) begin
            for (int k = 0; k < NL; k++) begin
                laneQ[k].delete();
                if (junk) begin
                    laneValidIn[k]           = 1'b1;
                    laneDataIn[k*DW +: DW]   = randBeat();
                end
            end
        end else begin
            for (int k = 0; k < NL; k++) begin
                if (laneValidOut[k]) begin
                    dueC = cyc + (randLat ? int'($urandom_range(1, 6)) : lat[k]);
                    if (laneQ[k].size() > 0 && int'(laneQ[k][laneQ[k].size()-1].due) >= dueC) begin
                        dueC = int'(laneQ[k][laneQ[k].size()-1].due) + 1;
                    end
                    r.d   = laneDataOut[k*DW +: DW];
                    r.due = 32'(dueC);
                    laneQ[k].push_back(r);
                end
                if (laneQ[k].size() > 0 && int'(laneQ[k][0].due) <= cyc) begin
                    laneValidIn[k]         = 1'b1;
                    laneDataIn[k*DW +: DW] = laneQ[k][0].d;
                    void'(laneQ[k].pop_front());
                end
            end
        end
    end

    // The single-lane instance echoes its dispatch in the same cycle.
    always @(posedge clk) begin
        #2;
        sLaneValidIn = reset ? 1'b0 : sLaneValidOut;
        sLaneDataIn  = sLaneDataOut;
    end

    task automatic applyStimulus(input bit vin, input bit rdy);
        validIn = vin;
        readyIn = rdy;
        dataIn  = randBeat();
    endtask

    task automatic doReset();
        reset   = 1'b1;
        validIn = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n       = 0;
        validIn = 1'b0;
        readyIn = 1'b1;
        while ((expQ.size() != 0 || mCount != 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (expQ.size() != 0 || mCount != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drainTimeout: got %0d beats left expected 0", expQ.size());
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit vin;
        bit rdy;
        int expCount;
        bit expAlm;
    } vec_t;

    vec_t vecs [$];

    initial begin
        logic [DW1-1:0] sExp [4];
        int             sOut;
        bit             sPrevStall;
        logic [DW1-1:0] sPrevData;

        // Credit-counter vectors: fill to ten with the output stalled, let
        // results settle, then one cycle with a beat in and a beat out.
        for (int i = 0; i < 10; i++) begin
            vecs.push_back('{1'b1, 1'b0, i + 1, 1'b0});
        end
        for (int i = 0; i < 4; i++) begin
            vecs.push_back('{1'b0, 1'b0, 10, 1'b0});
        end
        vecs.push_back('{1'b1, 1'b1, 10, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 9, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 8, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 8, 1'b0});

        reset    = 1'b1;
        validIn  = 1'b0;
        readyIn  = 1'b0;
        dataIn   = '0;
        sValidIn = 1'b0;
        sReadyIn = 1'b0;
        sDataIn  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] reset state");
        checkOutput("rstValidOut", DW'(validOut), '0);
        checkOutput("rstDataOut", dataOut, '0);
        checkOutput("rstOutstanding", DW'(outstanding), '0);
        checkOutput("rstAlmfull", DW'(almfullOut), '0);
        checkOutput("rstErr", DW'(overflowErr), '0);
        checkOutput("rstSingleValid", DW'(sValidOut), '0);

        $display("[TB] credit vectors");
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].vin, vecs[i].rdy);
            @(posedge clk);
            #1;
            checkOutput("tblCount", DW'(outstanding), DW'(vecs[i].expCount));
            checkOutput("tblAlmfull", DW'(almfullOut), DW'(vecs[i].expAlm));
        end
        waitDrain(200);

        $display("[TB] ordering with lane latencies 3/7/1/5");
        doReset();
        lat = '{3, 7, 1, 5};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1);
            @(posedge clk);
            #1;
        end
        waitDrain(200);
        checkOutput("orderCount", DW'(mOutIdx), DW'(8));
        checkOutput("throughput", DW'(outCyc[7] - outCyc[1]), DW'(6));

        $display("[TB] backpressure and overflow");
        doReset();
        lat = '{1, 1, 1, 1};
        for (int i = 0; i < CAP; i++) begin
            applyStimulus(1'b1, 1'b0);
            @(posedge clk);
            #1;
            if (i == THRESH - 2) begin
                checkOutput("belowThresh", DW'(almfullOut), '0);
            end
            if (i == THRESH - 1) begin
                checkOutput("atThresh", DW'(almfullOut), DW'(1'b1));
            end
        end
        validIn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("fullCount", DW'(outstanding), DW'(CAP));
        checkOutput("fullAlmfull", DW'(almfullOut), DW'(1'b1));
        applyStimulus(1'b1, 1'b0);
        @(posedge clk);
        #1;
        validIn = 1'b0;
        checkOutput("ovfErr", DW'(overflowErr), DW'(1'b1));
        checkOutput("ovfCount", DW'(outstanding), DW'(CAP));
        checkOutput("ovfNoDispatch", DW'(laneValidOut), '0);
        waitDrain(400);
        checkOutput("drainErrSticky", DW'(overflowErr), DW'(1'b1));
        checkOutput("drainAlmfull", DW'(almfullOut), '0);
        checkOutput("drainCount", DW'(outstanding), '0);
        applyStimulus(1'b1, 1'b0);
        @(posedge clk);
        #1;
        validIn = 1'b0;
        checkOutput("ptrAfterOvf", DW'(laneValidOut), DW'(4'b0001));
        waitDrain(100);

        $display("[TB] reset mid-run");
        doReset();
        lat = '{3, 7, 1, 5};
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b0);
            @(posedge clk);
            #1;
        end
        junk = 1'b1;
        doReset();
        junk = 1'b0;
        checkOutput("midValidOut", DW'(validOut), '0);
        checkOutput("midDataOut", dataOut, '0);
        checkOutput("midLaneValid", DW'(laneValidOut), '0);
        for (int k = 0; k < NL; k++) begin
            checkOutput("midLaneData", laneDataOut[k*DW +: DW], '0);
        end
        checkOutput("midCount", DW'(outstanding), '0);
        checkOutput("midAlmfull", DW'(almfullOut), '0);
        checkOutput("midErr", DW'(overflowErr), '0);
        applyStimulus(1'b1, 1'b0);
        @(posedge clk);
        #1;
        validIn = 1'b0;
        checkOutput("midFirstLane", DW'(laneValidOut), DW'(4'b0001));
        waitDrain(100);
        checkOutput("midDelivered", DW'(mOutIdx), DW'(1));

        $display("[TB] random traffic");
        doReset();
        randLat = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(!almfullOut && ($urandom_range(0, 9) < 6), $urandom_range(0, 9) < 7);
            @(posedge clk);
            #1;
        end
        waitDrain(600);
        randLat = 1'b0;
        checkOutput("randErr", DW'(overflowErr), '0);

        $display("[TB] single lane");
        for (int i = 0; i < 4; i++) begin
            sExp[i] = $urandom;
        end
        sOut       = 0;
        sPrevStall = 1'b0;
        sPrevData  = '0;
        for (int c = 0; c < 40; c++) begin
            sValidIn = (c < 4);
            sDataIn  = (c < 4) ? sExp[c] : '0;
            sReadyIn = (c % 2 == 0);
            if (sPrevStall) begin
                checkOutput("sHoldValid", DW'(sValidOut), DW'(1'b1));
                checkOutput("sHoldData", DW'(sDataOut), DW'(sPrevData));
            end
            if (sValidOut && sReadyIn) begin
                if (sOut < 4) begin
                    checkOutput("sData", DW'(sDataOut), DW'(sExp[sOut]));
                end else begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL sSpurious: got %0h expected no beat", sDataOut);
                end
                sOut++;
            end
            sPrevStall = sValidOut && !sReadyIn;
            sPrevData  = sDataOut;
            @(posedge clk);
            #1;
        end
        checkOutput("sCount", DW'(sOut), DW'(4));
        checkOutput("sErr", DW'(sOverflowErr), '0);
        checkOutput("sOutstanding", DW'(sOutstanding), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hc_lane_dispatch.md
Name: hc_lane_dispatch

Overview:
- Multi-lane successor to the single-kernel datapath hookup between the requestor and one kernel instance.
- Fans 512-bit cache-line beats from the requestor out to NUM_LANES kernel instances in round-robin order.
- Buffers each lane's results and re-serialises them in original input order toward the requestor.
- Provides credit-based almost-full backpressure, downstream ready handshake and sticky protocol-error reporting.

Parameters:
- DATA_WIDTH, 512, beat width for input, output and lane buses.
- NUM_LANES, 4, number of kernel lanes; legal range 1..8.
- FIFO_DEPTH, 16, per-lane result FIFO entries; power of 2, at least 2.
- ALMFULL_SLACK, 8, beats the upstream may still issue after almfull_out asserts; less than NUM_LANES*FIFO_DEPTH.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- data_in  in  DATA_WIDTH  beat from requestor.
- valid_in  in  1  beat qualifier; no ready, always accepted unless overflowing.
- almfull_out  out  1  upstream must stop issuing within ALMFULL_SLACK beats.
- data_out  out  DATA_WIDTH  reordered result beat.
- valid_out  out  1  result qualifier.
- ready_in  in  1  downstream accepts data_out when valid_out and ready_in are both high.
- lane_data_out  out  NUM_LANES*DATA_WIDTH  per-lane dispatched beat; lane k at slice [k*DATA_WIDTH +: DATA_WIDTH].
- lane_valid_out  out  NUM_LANES  per-lane dispatch strobe.
- lane_data_in  in  NUM_LANES*DATA_WIDTH  per-lane result.
- lane_valid_in  in  NUM_LANES  per-lane result strobe; each lane returns results in its own input order.
- outstanding  out  $clog2(NUM_LANES*FIFO_DEPTH)+1  beats accepted but not yet delivered.
- overflow_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset values: all outputs 0, dispatch and collect pointers 0, FIFOs empty, counter 0.
- Reset mid-operation discards every in-flight beat. Lane results arriving while reset is high are ignored.
- CAP = NUM_LANES*FIFO_DEPTH.
- Dispatch, 1-cycle latency:
  - A beat accepted in cycle t appears on lane disp_ptr in cycle t+1 with its lane_valid_out bit high for exactly 1 cycle.
  - disp_ptr then advances, wrapping from NUM_LANES-1 to 0.
  - lane_data_out slices are registered and only change when that lane is dispatched.
- Credit counter:
  - Increments on an accepted valid_in and decrements on an output handshake; both in the same cycle gives no change.
  - almfull_out = (outstanding >= CAP-ALMFULL_SLACK), decoded from the registered counter.
- Input overflow:
  - Condition: valid_in while outstanding == CAP and no handshake in the same cycle.
  - Effect: beat dropped, no dispatch, pointer unchanged, overflow_err set until reset.
- Lane FIFOs:
  - lane_valid_in[k] writes FIFO k.
  - Write while FIFO k is full: result dropped, overflow_err set.
  - Round-robin dispatch plus the credit limit guarantees a legal lane never fills.
- Collect:
  - col_ptr selects the FIFO holding the next in-order result.
  - The output register loads when it is empty, or is being handshaken, and FIFO[col_ptr] is non-empty. On load: FIFO pops and col_ptr advances with wrap.
  - A FIFO written at edge t can be read at edge t+1, so lane_valid_in to valid_out is 2 cycles when the path is idle.
  - Sustains 1 beat per cycle with ready_in held high.
- Output hold: while valid_out=1 and ready_in=0, data_out and valid_out stay stable.
- Head-of-line: if FIFO[col_ptr] is empty, nothing is emitted even when other lanes hold results; ordering is strict.
- NUM_LANES=1: degenerates to a credit-tracked FIFO of depth FIFO_DEPTH.

Test Plan:
- Ordering, 4 lanes: feed 8 beats 0..7 back-to-back; lanes echo with latencies 3/7/1/5 cycles → lane_valid_out hits lanes 0,1,2,3,0,1,2,3; data_out emits 0..7 in order, throughput 1 beat/cycle once lane 1 returns.
- Backpressure, 4 lanes: feed 64 beats with ready_in=0, lanes echo in 1 cycle → outstanding reaches 56 and almfull_out=1 from there; after ready_in=1 all 64 beats drain in order; outstanding returns to 0 and almfull_out to 0.
- Overflow, 4 lanes: with outstanding=64, assert valid_in → beat dropped, overflow_err=1, outstanding stays 64, disp_ptr unchanged; overflow_err still 1 after the drain.
- Simultaneous events: valid_in and an output handshake in the same cycle at outstanding=10 → outstanding stays 10; almfull_out unchanged.
- Reset mid-run: reset for 1 cycle with 20 beats in flight and a lane returning during reset → every output is 0 the cycle after reset; the returning beat is ignored; a new beat dispatches to lane 0.
- NUM_LANES=1, FIFO_DEPTH=4: 4 beats with an echo lane and ready_in toggling 1/0 → in-order output, data stable during stall cycles, overflow_err=0.
